// File: rtl/axis_axil_write_bridge_pkg.sv
// -----------------------------------------------------------------------------
// axil_bridge_pkg
// Shared types and constants for the AXI-Stream to AXI-Lite write bridge.
//   state_t     : packet parser states of the top level
//   ch_state_t  : states of the single-write AXI-Lite channel
//   dbg_t       : both FSM states bundled for the debug output
//   sat_inc16   : 16-bit saturating increment used by the status counters
// -----------------------------------------------------------------------------
package axil_bridge_pkg;

  typedef enum logic [2:0] {
    S_ADDR  = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_XFER = 2'd1,
    CH_RESP = 2'd2
  } ch_state_t;

  typedef struct packed {
    state_t    state;
    ch_state_t ch_state;
  } dbg_t;

  localparam logic [1:0] AXIL_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;
  localparam logic [3:0] AXIL_STRB_FULL    = 4'hF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axis_axil_write_bridge_if.sv
// -----------------------------------------------------------------------------
// AXIS_IF
// 32-bit AXI-Stream bundle carrying the command stream into the bridge.
//   tdata[31:0] : payload, first received byte in tdata[7:0]
//   tkeep[3:0]  : byte enables, only 4'hF is a well-formed command word
//   tvalid/tready : a beat transfers on a rising clk edge where both are 1;
//                 the transmitter holds tdata/tkeep/tlast stable while
//                 tvalid=1 and tready=0, and never withdraws tvalid early
//   tlast       : marks the final beat of a packet
// Modports: Transmitter drives the stream, Receiver consumes it.
// -----------------------------------------------------------------------------
interface AXIS_IF;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport Transmitter (output tdata, tkeep, tvalid, tlast, input tready);
  modport Receiver    (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_axil_write_bridge_axil_write_channel.sv
// -----------------------------------------------------------------------------
// axil_write_channel
// Executes exactly one AXI-Lite write at a time.
//   start_i          : pulse; latches addr_i/data_i and raises AWVALID+WVALID
//                      on the next cycle
//   awaddr_o/awvalid_o/awready_i : AW channel
//   wdata_o/wvalid_o/wready_i    : W channel
//   bresp_i/bvalid_i/bready_o    : B channel
//   issued_o         : both AW and W handshakes complete this cycle
//   done_o/resp_o    : B handshake this cycle, with the slave response
//   state_o          : current channel state for debug
// AW and W complete independently; each valid drops on its own handshake and
// the channel moves on only when both have completed (possibly same cycle).
// -----------------------------------------------------------------------------
module axil_write_channel
  import axil_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           data_i,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [31:0]           wdata_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic                  issued_o,
  output logic                  done_o,
  output logic [1:0]            resp_o,
  output ch_state_t             state_o
);

  ch_state_t             state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CH_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    addr_d    = addr_q;
    data_d    = data_q;
    bready_o  = 1'b0;
    issued_o  = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      CH_IDLE: begin
        if (start_i) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          addr_d    = addr_i;
          data_d    = data_i;
          state_d   = CH_XFER;
        end
      end
      CH_XFER: begin
        if (awready_i) awvalid_d = 1'b0;
        if (wready_i)  wvalid_d  = 1'b0;
        // Both sides done (now or earlier): write is fully issued.
        if (!awvalid_d && !wvalid_d) begin
          issued_o = 1'b1;
          state_d  = CH_RESP;
        end
      end
      CH_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          done_o  = 1'b1;
          state_d = CH_IDLE;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  assign awaddr_o  = addr_q;
  assign awvalid_o = awvalid_q;
  assign wdata_o   = data_q;
  assign wvalid_o  = wvalid_q;
  assign resp_o    = bresp_i;
  assign state_o   = state_q;

endmodule

// File: rtl/axis_axil_write_bridge.sv
// -----------------------------------------------------------------------------
// axis_axil_write_bridge
// Turns packets of (address word, data word) pairs arriving on a 32-bit
// AXI-Stream into AXI-Lite register writes, one outstanding write at a time,
// and reports per-packet completion/error status.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   in_axis_if        : command stream (AXIS_IF.Receiver)
//   m_axil_aw*/w*/b*  : AXI-Lite write master (awprot 0, wstrb F constant)
//   pkt_done          : one-cycle pulse at the end of every packet
//   pkt_error         : packet had a malformed word, overflow or bad bresp
//   pkt_write_count   : writes completed in the packet
//   stat_packets/stat_writes/stat_errors : 16-bit saturating counters
//   dbg_o             : parser and channel FSM states
// Build option: define AXIS_AXIL_WRITE_BRIDGE_STATUS_EN to implement the
// status counters; otherwise they read 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module axis_axil_write_bridge
  import axil_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WRITES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  AXIS_IF.Receiver              in_axis_if,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [31:0]           m_axil_wdata,
  output logic [3:0]            m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic                  pkt_done,
  output logic                  pkt_error,
  output logic [7:0]            pkt_write_count,
  output logic [15:0]           stat_packets,
  output logic [15:0]           stat_writes,
  output logic [15:0]           stat_errors,
  output dbg_t                  dbg_o
);

  localparam logic [7:0] MAX_W8 = 8'(MAX_WRITES);

  state_t                state_q, state_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  pkt_error_q, pkt_error_d;
  logic [7:0]            pkt_count_q, pkt_count_d;

  logic      tready_c;
  logic      beat;
  logic      well_formed;
  logic      finish;
  logic      ch_start;
  logic      ch_issued;
  logic      ch_done;
  logic [1:0] ch_resp;
  ch_state_t ch_state;

  assign beat        = in_axis_if.tvalid && in_axis_if.tready;
  assign well_formed = (in_axis_if.tkeep == 4'hF);

  // Parser state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_ADDR;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      addr_q      <= '0;
      pkt_done_q  <= 1'b0;
      pkt_error_q <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      pkt_done_q  <= pkt_done_d;
      pkt_error_q <= pkt_error_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // Parser next state. "finish" closes the packet using the updated
  // error/count values of this same cycle.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    addr_d      = addr_q;
    pkt_done_d  = 1'b0;
    pkt_error_d = pkt_error_q;
    pkt_count_d = pkt_count_q;
    tready_c    = 1'b0;
    ch_start    = 1'b0;
    finish      = 1'b0;
    unique case (state_q)
      S_ADDR: begin
        tready_c = 1'b1;
        if (beat) begin
          if (!well_formed) begin
            err_d = 1'b1;
            if (in_axis_if.tlast) finish = 1'b1;
            else                  state_d = S_DRAIN;
          end else if (in_axis_if.tlast) begin
            // Address word with no data word behind it.
            err_d  = 1'b1;
            finish = 1'b1;
          end else begin
            addr_d  = in_axis_if.tdata[ADDR_WIDTH-1:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        tready_c = 1'b1;
        if (beat) begin
          if (!well_formed) begin
            err_d = 1'b1;
            if (in_axis_if.tlast) finish = 1'b1;
            else                  state_d = S_DRAIN;
          end else begin
            last_d = in_axis_if.tlast;
            if (cnt_q == MAX_W8) begin
              // Write budget exhausted: skip this pair.
              err_d = 1'b1;
              if (in_axis_if.tlast) finish = 1'b1;
              else                  state_d = S_DRAIN;
            end else begin
              ch_start = 1'b1;
              state_d  = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        if (ch_issued) state_d = S_RESP;
      end
      S_RESP: begin
        if (ch_done) begin
          if (cnt_q != MAX_W8) cnt_d = cnt_q + 8'd1;
          if (ch_resp != AXIL_RESP_OKAY) err_d = 1'b1;
          if (last_q) finish = 1'b1;
          else        state_d = S_ADDR;
        end
      end
      S_DRAIN: begin
        tready_c = 1'b1;
        if (beat && in_axis_if.tlast) finish = 1'b1;
      end
      default: state_d = S_ADDR;
    endcase

    if (finish) begin
      pkt_done_d  = 1'b1;
      pkt_error_d = err_d;
      pkt_count_d = cnt_d;
      err_d       = 1'b0;
      cnt_d       = '0;
      last_d      = 1'b0;
      state_d     = S_ADDR;
    end
  end

  // tready is held low while reset is asserted, even though the parser
  // state is S_ADDR during that time.
  assign in_axis_if.tready = tready_c && !reset;

  axil_write_channel #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_channel (
    .clk       (clk),
    .reset     (reset),
    .start_i   (ch_start),
    .addr_i    (addr_q),
    .data_i    (in_axis_if.tdata),
    .awaddr_o  (m_axil_awaddr),
    .awvalid_o (m_axil_awvalid),
    .awready_i (m_axil_awready),
    .wdata_o   (m_axil_wdata),
    .wvalid_o  (m_axil_wvalid),
    .wready_i  (m_axil_wready),
    .bresp_i   (m_axil_bresp),
    .bvalid_i  (m_axil_bvalid),
    .bready_o  (m_axil_bready),
    .issued_o  (ch_issued),
    .done_o    (ch_done),
    .resp_o    (ch_resp),
    .state_o   (ch_state)
  );

  assign m_axil_awprot   = AXIL_PROT_DEFAULT;
  assign m_axil_wstrb    = AXIL_STRB_FULL;
  assign pkt_done        = pkt_done_q;
  assign pkt_error       = pkt_error_q;
  assign pkt_write_count = pkt_count_q;
  assign dbg_o.state     = state_q;
  assign dbg_o.ch_state  = ch_state;

`ifdef AXIS_AXIL_WRITE_BRIDGE_STATUS_EN
  logic [15:0] stat_packets_q;
  logic [15:0] stat_writes_q;
  logic [15:0] stat_errors_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_packets_q <= '0;
      stat_writes_q  <= '0;
      stat_errors_q  <= '0;
    end else begin
      if (pkt_done_q)                stat_packets_q <= sat_inc16(stat_packets_q);
      if (ch_done)                   stat_writes_q  <= sat_inc16(stat_writes_q);
      if (pkt_done_q && pkt_error_q) stat_errors_q  <= sat_inc16(stat_errors_q);
    end
  end

  assign stat_packets = stat_packets_q;
  assign stat_writes  = stat_writes_q;
  assign stat_errors  = stat_errors_q;
`else
  assign stat_packets = '0;
  assign stat_writes  = '0;
  assign stat_errors  = '0;
`endif

endmodule

// File: tb/tb_axis_axil_write_bridge.sv
// -----------------------------------------------------------------------------
// tb_axis_axil_write_bridge
// Directed bench for axis_axil_write_bridge: stream driver tasks, a
// responsive AXI-Lite slave with programmable ready delays and responses,
// a write scoreboard (exp_q) and a packet status monitor.
// -----------------------------------------------------------------------------
module tb_axis_axil_write_bridge;
  import axil_bridge_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  AXIS_IF axis_if ();

  logic [31:0] m_axil_awaddr;
  logic [2:0]  m_axil_awprot;
  logic        m_axil_awvalid;
  logic        m_axil_awready = 1'b0;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid;
  logic        m_axil_wready = 1'b0;
  logic [1:0]  m_axil_bresp = 2'b00;
  logic        m_axil_bvalid = 1'b0;
  logic        m_axil_bready;
  logic        pkt_done;
  logic        pkt_error;
  logic [7:0]  pkt_write_count;
  logic [15:0] stat_packets, stat_writes, stat_errors;
  dbg_t        dbg;

  axis_axil_write_bridge #(.ADDR_WIDTH(32), .MAX_WRITES(255)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_axis_if      (axis_if.Receiver),
    .m_axil_awaddr   (m_axil_awaddr),
    .m_axil_awprot   (m_axil_awprot),
    .m_axil_awvalid  (m_axil_awvalid),
    .m_axil_awready  (m_axil_awready),
    .m_axil_wdata    (m_axil_wdata),
    .m_axil_wstrb    (m_axil_wstrb),
    .m_axil_wvalid   (m_axil_wvalid),
    .m_axil_wready   (m_axil_wready),
    .m_axil_bresp    (m_axil_bresp),
    .m_axil_bvalid   (m_axil_bvalid),
    .m_axil_bready   (m_axil_bready),
    .pkt_done        (pkt_done),
    .pkt_error       (pkt_error),
    .pkt_write_count (pkt_write_count),
    .stat_packets    (stat_packets),
    .stat_writes     (stat_writes),
    .stat_errors     (stat_errors),
    .dbg_o           (dbg)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [63:0] exp_q[$];
  logic [31:0] got_aw_q[$];
  logic [31:0] got_w_q[$];
  logic [8:0]  got_pkt_q[$];
  logic [1:0]  bresp_plan[$];
  int          tready_viol = 0;

  // slave knobs
  int aw_delay = 0;
  int w_delay  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // AXI-Lite slave: decides ready/valid at negedge for the following posedge.
  int  aw_wait = 0, w_wait = 0;
  bit  aw_got = 0, w_got = 0, b_pending = 0;
  always @(negedge clk) begin
    if (reset) begin
      m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0;
      aw_wait = 0; w_wait = 0; aw_got = 0; w_got = 0; b_pending = 0;
    end else begin
      if (m_axil_awvalid && !aw_got) begin
        if (aw_wait >= aw_delay) begin
          m_axil_awready = 1'b1; aw_got = 1; got_aw_q.push_back(m_axil_awaddr);
        end else begin
          m_axil_awready = 1'b0; aw_wait++;
        end
      end else begin
        m_axil_awready = 1'b0;
        if (!m_axil_awvalid) aw_wait = 0;
      end
      if (m_axil_wvalid && !w_got) begin
        if (w_wait >= w_delay) begin
          m_axil_wready = 1'b1; w_got = 1; got_w_q.push_back(m_axil_wdata);
        end else begin
          m_axil_wready = 1'b0; w_wait++;
        end
      end else begin
        m_axil_wready = 1'b0;
        if (!m_axil_wvalid) w_wait = 0;
      end
      if (b_pending) begin
        m_axil_bvalid = 1'b0; b_pending = 0; aw_got = 0; w_got = 0;
      end else if (aw_got && w_got && !m_axil_bvalid && !m_axil_awvalid && !m_axil_wvalid) begin
        m_axil_bvalid = 1'b1;
        m_axil_bresp  = (bresp_plan.size() > 0) ? bresp_plan.pop_front() : 2'b00;
        if (m_axil_bready) b_pending = 1;
      end else if (m_axil_bvalid && m_axil_bready) begin
        b_pending = 1;
      end
    end
  end

  // packet status / stream rule monitor
  always @(negedge clk) begin
    if (!reset && pkt_done) got_pkt_q.push_back({pkt_error, pkt_write_count});
    if (axis_if.tready && (m_axil_awvalid || m_axil_wvalid || m_axil_bready)) tready_viol++;
  end

  // driver tasks (drive #1 after posedge)
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit ok = 0;
    axis_if.tdata = d; axis_if.tkeep = k; axis_if.tlast = l; axis_if.tvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (axis_if.tready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    axis_if.tvalid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $error("FAIL beat_timeout: got no tready expected tready for %0h", d);
    end
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] d, input logic l);
    send_beat(a, 4'hF, 1'b0);
    send_beat(d, 4'hF, l);
    exp_q.push_back({a, d});
  endtask

  task automatic wait_pkt(input string tag, input logic e, input logic [7:0] c);
    bit ok = 0;
    logic [8:0] p;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (got_pkt_q.size() > 0) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $error("FAIL %s_done: got no pkt_done expected pkt_done", tag);
    end else begin
      p = got_pkt_q.pop_front();
      check({tag, "_err"}, 64'(p[8]), 64'(e));
      check({tag, "_cnt"}, 64'(p[7:0]), 64'(c));
    end
    @(posedge clk); #1;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nw_aw"}, 64'(got_aw_q.size()), 64'(exp_q.size()));
    check({tag, "_nw_w"}, 64'(got_w_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_aw_q.size() > 0 && got_w_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      check({tag, "_wr"}, {got_aw_q.pop_front(), got_w_q.pop_front()}, e);
    end
    exp_q.delete(); got_aw_q.delete(); got_w_q.delete();
  endtask

  task automatic check_stats(input string tag, input int np, input int nw, input int ne);
`ifdef AXIS_AXIL_WRITE_BRIDGE_STATUS_EN
    check({tag, "_stat_pk"}, 64'(stat_packets), 64'(np));
    check({tag, "_stat_wr"}, 64'(stat_writes), 64'(nw));
    check({tag, "_stat_er"}, 64'(stat_errors), 64'(ne));
`else
    check({tag, "_stat_pk"}, 64'(stat_packets), 64'(0));
    check({tag, "_stat_wr"}, 64'(stat_writes), 64'(0));
    check({tag, "_stat_er"}, 64'(stat_errors), 64'(0));
    if (np < 0 || nw < 0 || ne < 0) $display("negative stat expectation");
`endif
  endtask

  initial begin
    axis_if.tdata = '0; axis_if.tkeep = '0; axis_if.tlast = 1'b0; axis_if.tvalid = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", 64'(axis_if.tready), 64'(0));
    check("rst_awvalid", 64'(m_axil_awvalid), 64'(0));
    check("rst_wvalid", 64'(m_axil_wvalid), 64'(0));
    check("rst_bready", 64'(m_axil_bready), 64'(0));
    check("rst_done", 64'(pkt_done), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_err", 64'(pkt_error), 64'(0));
    check("rst_cnt", 64'(pkt_write_count), 64'(0));
    check("rst_state", 64'(dbg.state), 64'(S_ADDR));
    check("awprot", 64'(m_axil_awprot), 64'(0));
    check("wstrb", 64'(m_axil_wstrb), 64'hF);
    check_stats("rst", 0, 0, 0);
    @(posedge clk); #1;

    // single write
    send_pair(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    wait_pkt("t1", 1'b0, 8'd1);
    check_writes("t1");

    // three writes against a slow slave with independent AW/W stalls
    aw_delay = 5; w_delay = 2;
    send_pair(32'h100, 32'h1111_1111, 1'b0);
    send_pair(32'h104, 32'h2222_2222, 1'b0);
    send_pair(32'h108, 32'h3333_3333, 1'b1);
    wait_pkt("t2", 1'b0, 8'd3);
    check_writes("t2");
    check("t2_tready_viol", 64'(tready_viol), 64'(0));
    aw_delay = 0; w_delay = 0;

    // SLVERR on the second of two writes
    bresp_plan.push_back(2'b00); bresp_plan.push_back(2'b10);
    send_pair(32'h200, 32'h0000_000A, 1'b0);
    send_pair(32'h204, 32'h0000_000B, 1'b1);
    wait_pkt("t3", 1'b1, 8'd2);
    check_writes("t3");

    // orphan address word, then a normal packet
    send_pair(32'h300, 32'h0000_000C, 1'b0);
    send_beat(32'h304, 4'hF, 1'b1);
    wait_pkt("t4a", 1'b1, 8'd1);
    send_pair(32'h400, 32'h0000_000D, 1'b1);
    wait_pkt("t4b", 1'b0, 8'd1);
    check_writes("t4");

    // partial tkeep on an address word drains the rest of the packet
    send_pair(32'h500, 32'h0000_000E, 1'b0);
    send_beat(32'h504, 4'h3, 1'b0);
    send_beat(32'h0000_1234, 4'hF, 1'b0);
    send_beat(32'h0000_5678, 4'hF, 1'b1);
    wait_pkt("t5", 1'b1, 8'd1);
    check_writes("t5");
    repeat (3) @(negedge clk);
    check_stats("t5", 6, 9, 3);
    check("t5_tready_viol", 64'(tready_viol), 64'(0));
    @(posedge clk); #1;

    // reset while a write is stalled in S_WRITE
    aw_delay = 10; w_delay = 10;
    send_beat(32'h600, 4'hF, 1'b0);
    send_beat(32'h0000_000F, 4'hF, 1'b0);
    check("t6_in_write", 64'(dbg.state), 64'(S_WRITE));
    check("t6_awvalid_pre", 64'(m_axil_awvalid), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_awvalid", 64'(m_axil_awvalid), 64'(0));
    check("t6_wvalid", 64'(m_axil_wvalid), 64'(0));
    check("t6_bready", 64'(m_axil_bready), 64'(0));
    check("t6_tready", 64'(axis_if.tready), 64'(0));
    check("t6_state", 64'(dbg.state), 64'(S_ADDR));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    aw_delay = 0; w_delay = 0;
    got_aw_q.delete(); got_w_q.delete(); got_pkt_q.delete();
    send_pair(32'h700, 32'h0000_0077, 1'b1);
    wait_pkt("t6", 1'b0, 8'd1);
    check_writes("t6");
    repeat (3) @(negedge clk);
    check_stats("t6", 1, 1, 0);
    check("t6_extra_pkts", 64'(got_pkt_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
